// File: rtl/inst_buffer_if.sv
// Fetch/decode packet type and the instruction-buffer port bundle.
// The buffer sits on the slave side; fetch/decode (or a bench) drive the master side.
package inst_buffer_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] PC;
      logic [31:0] NPC;
   } IF_ID_PACKET;

   localparam IF_ID_PACKET EMPTY_PKT = '{
      valid: 1'b0,
      inst:  NOP,
      PC:    32'h0,
      NPC:   32'h0
   };

endpackage

interface inst_buffer_if
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = 8
) ();

   localparam int CW = $clog2(DEPTH + 1);

   logic              flush;
   IF_ID_PACKET       if_packet;
   logic              id_ready;
   IF_ID_PACKET       id_packet;
   logic              if_stall;
   logic [CW-1:0]     count;

   modport master (
      output flush,
      output if_packet,
      output id_ready,
      input  id_packet,
      input  if_stall,
      input  count
   );

   modport slave (
      input  flush,
      input  if_packet,
      input  id_ready,
      output id_packet,
      output if_stall,
      output count
   );

endinterface

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction queue with registered full stall and redirect flush.
// Define INST_BUFFER_BYPASS_EN for a zero-latency path through an empty buffer.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   inst_buffer_if.slave      bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   IF_ID_PACKET   mem_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          stall_q, stall_d;

   logic          empty;
   logic          byp;
   logic          enq;
   logic          deq;
   IF_ID_PACKET   head_pkt;
   IF_ID_PACKET   wr_pkt;

   assign empty = (count_q == '0);

`ifdef INST_BUFFER_BYPASS_EN
   assign byp = empty
              & bus.if_packet.valid
              & bus.id_ready
              & ~bus.flush;
`else
   assign byp = 1'b0;
`endif

   // a bypassed packet is consumed directly and never written
   assign enq = bus.if_packet.valid
              & ~stall_q
              & ~bus.flush
              & ~byp;

   assign deq = ~empty
              & bus.id_ready
              & ~bus.flush;

   always_comb begin
      wr_pkt       = bus.if_packet;
      wr_pkt.valid = 1'b1;
   end

   always_comb begin
      head_pkt       = mem_q[head_q];
      head_pkt.valid = 1'b1;
   end

   always_comb begin
      bus.id_packet = EMPTY_PKT;
      if (byp) begin
         bus.id_packet = bus.if_packet;
      end else if (!empty && !bus.flush) begin
         bus.id_packet = head_pkt;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      stall_d = 1'b0;
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(deq);
         tail_d  = tail_q + PW'(enq);
         count_d = count_q + CW'(enq) - CW'(deq);
         stall_d = (count_d == FULL);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stall_q <= stall_d;
      end
   end

   always_ff @(posedge clock) begin
      if (enq) begin
         mem_q[tail_q] <= wr_pkt;
      end
   end

   assign bus.if_stall = stall_q;
   assign bus.count    = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: stimulus pushes expected packets,
// a negedge monitor pops them on every decode handshake.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic clk;
   logic rst;

   inst_buffer_if #(.DEPTH(DEPTH)) bus ();

   inst_buffer #(.DEPTH(DEPTH)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   IF_ID_PACKET exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic IF_ID_PACKET mk(input logic v, input logic [31:0] pc);
      IF_ID_PACKET p;
      p.valid = v;
      p.inst  = v ? (32'h0010_0093 + pc) : NOP;
      p.PC    = pc;
      p.NPC   = pc + 32'd4;
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.if_packet = EMPTY_PKT;
      bus.id_ready  = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic drain();
      int n;
      bus.if_packet = EMPTY_PKT;
      bus.id_ready  = 1'b1;
      n = 0;
      while (bus.count != 0 && n < 40) begin
         step();
         n++;
      end
      chk("drain_done", 32'(bus.count), 32'd0);
      bus.id_ready = 1'b0;
   endtask

   // Decode-side monitor: a handshake completes at the next posedge
   always @(negedge clk) begin
      if (!rst && bus.id_packet.valid && bus.id_ready) begin
         IF_ID_PACKET e;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL mon_extra: got pc %h want none",
                     bus.id_packet.PC);
         end else begin
            e = exp_q.pop_front();
            if (bus.id_packet.PC   !== e.PC  ||
                bus.id_packet.inst !== e.inst ||
                bus.id_packet.NPC  !== e.NPC) begin
               bad++;
               $display("FAIL mon_pkt: got pc %h inst %h want pc %h inst %h",
                        bus.id_packet.PC, bus.id_packet.inst, e.PC, e.inst);
            end
         end
      end
   end

   initial begin
      idle_in();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_stall", 32'(bus.if_stall), 32'd0);
      chk("rst_valid", 32'(bus.id_packet.valid), 32'd0);
      chk("rst_inst", bus.id_packet.inst, NOP);
      chk("rst_pc", bus.id_packet.PC, 32'd0);
      chk("rst_npc", bus.id_packet.NPC, 32'd0);

      // three packets, decode not ready
      for (int i = 0; i < 3; i++) begin
         bus.if_packet = mk(1'b1, 32'(4 * i));
         exp_q.push_back(bus.if_packet);
         step();
         chk("fill3_cnt", 32'(bus.count), 32'(i + 1));
         chk("fill3_pc", bus.id_packet.PC, 32'h0);
         chk("fill3_stall", 32'(bus.if_stall), 32'd0);
      end
      drain();

      // saturate at DEPTH
      for (int i = 0; i < 10; i++) begin
         bus.if_packet = mk(1'b1, 32'h1000 + 32'(4 * i));
         if (i < DEPTH) exp_q.push_back(bus.if_packet);
         step();
         chk("full_cnt", 32'(bus.count), (i + 1 < DEPTH) ? 32'(i + 1) : 32'(DEPTH));
         chk("full_stall", 32'(bus.if_stall), (i >= DEPTH - 1) ? 32'd1 : 32'd0);
      end
      bus.if_packet = EMPTY_PKT;
      bus.id_ready  = 1'b1;
      step();
      bus.id_ready  = 1'b0;
      chk("unfull_cnt", 32'(bus.count), 32'd7);
      chk("unfull_stall", 32'(bus.if_stall), 32'd0);
      drain();

      // steady stream, pointers wrap twice
      bus.id_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.if_packet = mk(1'b1, 32'(4 * i));
         exp_q.push_back(bus.if_packet);
         step();
         chk("stream_le1", 32'(bus.count <= 1), 32'd1);
      end
      drain();

      // flush with five held and one incoming
      for (int i = 0; i < 5; i++) begin
         bus.if_packet = mk(1'b1, 32'h2000 + 32'(4 * i));
         step();
      end
      chk("pre_flush_cnt", 32'(bus.count), 32'd5);
      bus.flush     = 1'b1;
      bus.id_ready  = 1'b1;
      bus.if_packet = mk(1'b1, 32'h100);
      #1;
      chk("flush_valid", 32'(bus.id_packet.valid), 32'd0);
      step();
      bus.flush     = 1'b0;
      bus.id_ready  = 1'b0;
      chk("post_flush_cnt", 32'(bus.count), 32'd0);
      chk("post_flush_stall", 32'(bus.if_stall), 32'd0);
      bus.if_packet = mk(1'b1, 32'h200);
      exp_q.push_back(bus.if_packet);
      #1;
      chk("pre_enq_valid", 32'(bus.id_packet.valid), 32'd0);
      step();
      bus.if_packet = EMPTY_PKT;
      chk("after_flush_valid", 32'(bus.id_packet.valid), 32'd1);
      chk("after_flush_pc", bus.id_packet.PC, 32'h200);
      drain();

      // alternating fetch bubbles
      for (int i = 0; i < 8; i++) begin
         bus.if_packet = mk(i % 2 == 0, 32'h300 + 32'(4 * i));
         if (i % 2 == 0) exp_q.push_back(bus.if_packet);
         step();
         chk("bubble_cnt", 32'(bus.count), 32'(i / 2 + 1));
      end
      drain();

`ifdef INST_BUFFER_BYPASS_EN
      bus.if_packet = mk(1'b1, 32'h40);
      bus.id_ready  = 1'b1;
      exp_q.push_back(bus.if_packet);
      #1;
      chk("byp_valid", 32'(bus.id_packet.valid), 32'd1);
      chk("byp_pc", bus.id_packet.PC, 32'h40);
      step();
      chk("byp_cnt", 32'(bus.count), 32'd0);
      bus.if_packet = mk(1'b1, 32'h44);
      bus.id_ready  = 1'b0;
      exp_q.push_back(bus.if_packet);
      step();
      chk("nobyp_cnt", 32'(bus.count), 32'd1);
      drain();
`endif

      idle_in();
      step();
      step();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Single-issue instruction queue between the fetch stage and decode. Accepts one `IF_ID_PACKET` per cycle from fetch, holds up to `DEPTH` packets in program order, and presents the oldest to decode under a valid/ready handshake. Raises a registered stall back to fetch when full. Discards all contents on a redirect flush (EX branch resolution or ROB target).

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥ 2.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash all held entries and the incoming packet; driven on any PC redirect (`certain_branch_req` or `rob_target_req`).
- `if_packet`  in  `IF_ID_PACKET`  packet from fetch; `if_packet.valid` qualifies it.
- `id_ready`  in  1  decode accepts `id_packet` this cycle.
- `id_packet`  out  `IF_ID_PACKET`  oldest buffered packet; `id_packet.valid` = buffer non-empty.
- `if_stall`  out  1  registered; buffer full, fetch must hold PC and repeat the packet.
- `count`  out  `$clog2(DEPTH+1)`  number of occupied entries.

## Operation
- Storage: circular array of `DEPTH` packets, `head` (oldest) and `tail` (next write) pointers of `$clog2(DEPTH)` bits, plus `count`. Pointers wrap modulo `DEPTH` by natural overflow.
- enq = `if_packet.valid && !if_stall && !flush`. On enq, write `if_packet` at `tail`, then `tail+1`.
- deq = `id_packet.valid && id_ready && !flush`. On deq, `head+1`.
- `count` next = count + enq − deq. Simultaneous enq and deq leaves count unchanged, including at count = 1.
- Full (count = DEPTH): `if_stall` = 1; enq blocked even when deq occurs the same cycle. Count drops to DEPTH−1 and `if_stall` clears the following cycle.
- Empty (count = 0): `id_packet.valid` = 0, `inst` = `NOP`, `PC` = `NPC` = 0. An id_ready while empty has no effect.
- Flush has top priority. At the posedge ending a flush cycle: head = tail = 0, count = 0, `if_stall` = 0. The incoming packet that cycle is dropped. During the flush cycle, `id_packet.valid` is forced 0 so decode consumes nothing.
- Packets with `valid` = 0 (fetch NOP bubbles) are never stored.
- Stored `valid` bit is always 1; `id_packet.valid` is derived from count, not from storage.

## Timing
- Reset: count = 0, head = tail = 0, `if_stall` = 0, `id_packet` = {valid 0, inst `NOP`, PC 0, NPC 0}. Storage contents are don't-care.
- Reset asserted mid-operation behaves identically to flush plus clearing `if_stall`; it takes priority over flush.
- Latency (base build): a packet enqueued at posedge N appears on `id_packet` in cycle N+1 at the earliest. Throughput is 1 packet/cycle in steady state.
- `if_stall` is a flop output: `if_stall` next = (count next == DEPTH). There is no combinational path from `id_ready` or `if_packet` to `if_stall`.
- `id_packet` is a mux of the head entry. It has no combinational dependence on `if_packet` unless bypass is enabled.

## Configuration
- `INST_BUFFER_BYPASS_EN` defined: when count = 0, `if_packet.valid`, `id_ready`, and `!flush` all hold in the same cycle, `if_packet` drives `id_packet` combinationally and is consumed without being written; count stays 0. This gives 0-cycle latency through an empty buffer. If `id_ready` = 0 in that case, the packet is enqueued normally.
- Undefined: no bypass. `id_packet` always comes from storage, and minimum latency is 1 cycle.

## Test plan
- Reset, then 3 consecutive valid packets (PC 0x0, 0x4, 0x8) with `id_ready` = 0 → count 1, 2, 3 on successive cycles; `id_packet.PC` = 0x0 from cycle after first enq; `if_stall` = 0.
- DEPTH = 8, `id_ready` = 0, 10 valid packets offered → count saturates at 8; `if_stall` = 1 from the cycle after the 8th enq; packets 9–10 are not stored; one cycle of `id_ready` = 1 → count 7 and `if_stall` = 0 the next cycle.
- Steady stream with `id_ready` = 1 over 20 packets (PC 0x0..0x4C) → decode receives PCs in order with none missing or duplicated; head/tail wrap twice; count stays ≤ 1 (base build).
- Count = 5, assert `flush` with a valid incoming packet PC 0x100 → `id_packet.valid` = 0 that cycle; next cycle count = 0; 0x100 is never output; the next packet PC 0x200 appears at `id_packet` one cycle after enq.
- Fetch bubbles: alternate valid/invalid packets (inst `NOP`, valid 0) → only valid packets are counted and output.
- With `INST_BUFFER_BYPASS_EN`, empty buffer, valid PC 0x40, `id_ready` = 1 → `id_packet.PC` = 0x40 in the same cycle, count remains 0. Repeat with `id_ready` = 0 → count = 1 next cycle.
